// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA 640x480@60 timing constants, the sync/blank bundle carried
// through the output delay line, and a helper that sums porch/sync spans.
package vga_timing_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   function automatic int span_total(input int visible, input int fp,
                                     input int sync, input int bp);
      return visible + fp + sync + bp;
   endfunction

   localparam int VGA_H_TOTAL  = span_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam int VGA_V_TOTAL  = span_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
   localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
   localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
   } sync_bits_t;

   // Idle (reset) value: syncs deasserted, display blanked.
   localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line
// Shift register of sync_bits_t that advances only when en is high.
// Ports:
//   clk   - clock
//   rst_n - async active-low reset; all stages return to SYNC_IDLE
//   en    - shift enable (one pixel period per enabled edge)
//   d     - input sync bundle
//   q     - output of the last stage (d itself when DEPTH = 0)
module sync_delay_line
   import vga_timing_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  sync_bits_t d,
   output sync_bits_t q
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q = d;
      end else begin : g_pipe
         sync_bits_t stage [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
            end else if (en) begin
               stage[0] <= d;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing from the 50 MHz system clock: a divide-by-two pixel
// enable, horizontal/vertical counters, registered sync/blank decode that is
// delayed by PIPE_DELAY pixel periods (0..3) to line up with the colour
// mapper's RAM latency, and frame-level pulses for game logic.
// Ports:
//   Clk          - 50 MHz system clock
//   Reset_n      - async active-low reset
//   DrawX/DrawY  - current pixel counters (no delay)
//   pixel_en     - high on every second Clk; counters move on these edges
//   VGA_CLK      - 25 MHz pixel clock (same as pixel_en)
//   VGA_HS/VS    - active-low syncs, delayed 1 + PIPE_DELAY pixels
//   VGA_BLANK_N  - high in the active region, same delay as the syncs
//   frame_start  - one Clk pulse at (0,0) while pixel_en, from the 2nd frame on
//   vblank_start - one Clk pulse at (0,V_VISIBLE) while pixel_en
//   frame_count  - frames completed since reset, wraps
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = VGA_H_VISIBLE,
   parameter int H_FP       = VGA_H_FP,
   parameter int H_SYNC     = VGA_H_SYNC,
   parameter int H_BP       = VGA_H_BP,
   parameter int V_VISIBLE  = VGA_V_VISIBLE,
   parameter int V_FP       = VGA_V_FP,
   parameter int V_SYNC     = VGA_V_SYNC,
   parameter int V_BP       = VGA_V_BP,
   parameter int PIPE_DELAY = 1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        pixel_en,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        frame_start,
   output logic        vblank_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic        pix_phase;
   logic [9:0]  hc;
   logic [9:0]  vc;
   logic [15:0] frame_cnt;
   logic        seen_wrap;
   logic        frame_start_q;
   logic        vblank_start_q;
   sync_bits_t  sync_now;
   sync_bits_t  sync_s0;
   sync_bits_t  sync_out;

   always_comb begin
      sync_now         = SYNC_IDLE;
      sync_now.hs      = ~((hc >= HS_FIRST) && (hc <= HS_LAST));
      sync_now.vs      = ~((vc >= VS_FIRST) && (vc <= VS_LAST));
      sync_now.blank_n = (hc < H_VIS_END) && (vc < V_VIS_END);
   end

   // The pulses are registered one Clk ahead: on the non-pixel edge the
   // counters cannot change, so the current count is also the count held
   // during the following pixel_en cycle, giving zero latency to DrawX/DrawY.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_phase      <= 1'b0;
         hc             <= '0;
         vc             <= '0;
         frame_cnt      <= '0;
         seen_wrap      <= 1'b0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
         sync_s0        <= SYNC_IDLE;
      end else begin
         pix_phase      <= ~pix_phase;
         frame_start_q  <= ~pix_phase && (hc == '0) && (vc == '0) && seen_wrap;
         vblank_start_q <= ~pix_phase && (hc == '0) && (vc == V_VIS_END);
         if (pix_phase) begin
            sync_s0 <= sync_now;
            if (hc == H_LAST) begin
               hc <= '0;
               if (vc == V_LAST) begin
                  vc        <= '0;
                  frame_cnt <= frame_cnt + 16'd1;
                  seen_wrap <= 1'b1;
               end else begin
                  vc <= vc + 10'd1;
               end
            end else begin
               hc <= hc + 10'd1;
            end
         end
      end
   end

   sync_delay_line #(
      .DEPTH (PIPE_DELAY)
   ) u_sync_delay (
      .clk   (Clk),
      .rst_n (Reset_n),
      .en    (pix_phase),
      .d     (sync_s0),
      .q     (sync_out)
   );

   assign DrawX        = hc;
   assign DrawY        = vc;
   assign pixel_en     = pix_phase;
   assign VGA_CLK      = pix_phase;
   assign VGA_HS       = sync_out.hs;
   assign VGA_VS       = sync_out.vs;
   assign VGA_BLANK_N  = sync_out.blank_n;
   assign frame_start  = frame_start_q;
   assign vblank_start = vblank_start_q;
   assign frame_count  = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench: one full-size instance (640x480, PIPE_DELAY=1) for reset and
// line timing, and two shrunken-raster instances (16x8 totals, PIPE_DELAY 0
// and 3) so that whole frames fit in a short run.
module tb_vga_timing_gen;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;

   always #10 Clk = ~Clk;

   logic [9:0]  d_x, d_y, a_x, a_y, b_x, b_y;
   logic        d_pe, d_vclk, d_hs, d_vs, d_bn, d_fs, d_vb;
   logic        a_pe, a_vclk, a_hs, a_vs, a_bn, a_fs, a_vb;
   logic        b_pe, b_vclk, b_hs, b_vs, b_bn, b_fs, b_vb;
   logic [15:0] d_fc, a_fc, b_fc;

   vga_timing_gen u_d (
      .Clk (Clk), .Reset_n (Reset_n), .DrawX (d_x), .DrawY (d_y),
      .pixel_en (d_pe), .VGA_CLK (d_vclk), .VGA_HS (d_hs), .VGA_VS (d_vs),
      .VGA_BLANK_N (d_bn), .frame_start (d_fs), .vblank_start (d_vb),
      .frame_count (d_fc)
   );

   vga_timing_gen #(
      .H_VISIBLE (10), .H_FP (2), .H_SYNC (3), .H_BP (1),
      .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .PIPE_DELAY (0)
   ) u_a (
      .Clk (Clk), .Reset_n (Reset_n), .DrawX (a_x), .DrawY (a_y),
      .pixel_en (a_pe), .VGA_CLK (a_vclk), .VGA_HS (a_hs), .VGA_VS (a_vs),
      .VGA_BLANK_N (a_bn), .frame_start (a_fs), .vblank_start (a_vb),
      .frame_count (a_fc)
   );

   vga_timing_gen #(
      .H_VISIBLE (10), .H_FP (2), .H_SYNC (3), .H_BP (1),
      .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .PIPE_DELAY (3)
   ) u_b (
      .Clk (Clk), .Reset_n (Reset_n), .DrawX (b_x), .DrawY (b_y),
      .pixel_en (b_pe), .VGA_CLK (b_vclk), .VGA_HS (b_hs), .VGA_VS (b_vs),
      .VGA_BLANK_N (b_bn), .frame_start (b_fs), .vblank_start (b_vb),
      .frame_count (b_fc)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int w;
      int fs_cnt, fs_first, fs_last, vb_cnt, vb_first, vs_low_a, vs_low_b;
      int a_fall, b_fall, a_w, b_w;

      // ---------------- reset state ----------------
      Reset_n = 1'b0;
      repeat (5) @(negedge Clk);
      check("rst_x",   32'(d_x), 0);
      check("rst_y",   32'(d_y), 0);
      check("rst_hs",  32'(d_hs), 1);
      check("rst_vs",  32'(d_vs), 1);
      check("rst_bn",  32'(d_bn), 0);
      check("rst_fc",  32'(d_fc), 0);
      check("rst_pe",  32'(d_pe), 0);
      check("rst_bn3", 32'(b_bn), 0);

      Reset_n = 1'b1;
      @(negedge Clk);
      check("rel_pe1",   32'(d_pe), 1);
      check("rel_vclk1", 32'(d_vclk), 1);
      check("rel_x0",    32'(d_x), 0);
      @(negedge Clk);
      check("rel_x1",  32'(d_x), 1);
      check("rel_pe0", 32'(d_pe), 0);
      check("bn_lat1_early", 32'(d_bn), 0);
      check("bn_lat0",       32'(a_bn), 1);
      repeat (2) @(negedge Clk);
      check("bn_lat1", 32'(d_bn), 1);
      check("bn_lat3_early", 32'(b_bn), 0);

      // ---------------- full-size line timing ----------------
      n = 0;
      while (d_x != 10'd641 && n < 3000) begin @(negedge Clk); n++; end
      check("bn_x641", 32'(d_bn), 1);
      n = 0;
      while (d_x != 10'd642 && n < 8) begin @(negedge Clk); n++; end
      check("bn_x642", 32'(d_bn), 0);

      n = 0;
      while (d_x != 10'd656 && n < 64) begin @(negedge Clk); n++; end
      check("x656_reached", 32'(d_x), 656);
      repeat (3) @(negedge Clk);
      check("hs_pre_fall", 32'(d_hs), 1);
      @(negedge Clk);
      check("hs_fall_4clk", 32'(d_hs), 0);
      w = 0;
      while (d_hs == 1'b0 && w < 400) begin w++; @(negedge Clk); end
      check("hs_width", 32'(w), 192);

      n = 0;
      while (d_x != 10'd799 && n < 400) begin @(negedge Clk); n++; end
      check("x799_y", 32'(d_y), 0);
      repeat (2) @(negedge Clk);
      check("hwrap_x", 32'(d_x), 0);
      check("hwrap_y", 32'(d_y), 1);
      n = 0;
      do begin @(negedge Clk); n++; end while (!(d_x == 10'd0 && d_y == 10'd2) && n < 4000);
      check("line_period", 32'(n), 1600);
      check("line_vs", 32'(d_vs), 1);
      check("line_fc", 32'(d_fc), 0);

      // ---------------- frames on the shrunken rasters ----------------
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      fs_cnt = 0; fs_first = 0; fs_last = 0; vb_cnt = 0; vb_first = 0;
      vs_low_a = 0; vs_low_b = 0;
      for (int i = 1; i <= 600; i++) begin
         @(negedge Clk);
         if (a_fs) begin
            fs_cnt++;
            if (fs_first == 0) fs_first = i;
            fs_last = i;
         end
         if (a_vb) begin
            vb_cnt++;
            if (vb_first == 0) vb_first = i;
         end
         if (!a_vs) vs_low_a++;
         if (!b_vs) vs_low_b++;
      end
      check("fs_count", 32'(fs_cnt), 2);
      check("fs_first", 32'(fs_first), 257);
      check("fs_last",  32'(fs_last), 513);
      check("vb_count", 32'(vb_cnt), 2);
      check("vb_first", 32'(vb_first), 129);
      check("vs_low_p0", 32'(vs_low_a), 128);
      check("vs_low_p3", 32'(vs_low_b), 128);
      check("fc_two_p0", 32'(a_fc), 2);
      check("fc_two_p3", 32'(b_fc), 2);

      // ---------------- HS / BLANK_N delay vs PIPE_DELAY ----------------
      n = 0;
      while (a_x != 10'd11 && n < 64) begin @(negedge Clk); n++; end
      n = 0;
      while (a_x != 10'd12 && n < 8) begin @(negedge Clk); n++; end
      check("x12_reached", 32'(a_x), 12);
      a_fall = 0; b_fall = 0; a_w = 0; b_w = 0;
      for (int j = 1; j <= 30; j++) begin
         @(negedge Clk);
         if (!a_hs) begin a_w++; if (a_fall == 0) a_fall = j; end
         if (!b_hs) begin b_w++; if (b_fall == 0) b_fall = j; end
      end
      check("hs_fall_p0",  32'(a_fall), 2);
      check("hs_fall_p3",  32'(b_fall), 8);
      check("hs_width_p0", 32'(a_w), 6);
      check("hs_width_p3", 32'(b_w), 6);

      n = 0;
      while (!(a_y == 10'd1 && a_x == 10'd9) && n < 600) begin @(negedge Clk); n++; end
      n = 0;
      while (a_x != 10'd10 && n < 8) begin @(negedge Clk); n++; end
      check("x10_reached", 32'(a_x), 10);
      a_fall = 0; b_fall = 0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge Clk);
         if (!a_bn && a_fall == 0) a_fall = j;
         if (!b_bn && b_fall == 0) b_fall = j;
      end
      check("bn_fall_p0", 32'(a_fall), 2);
      check("bn_fall_p3", 32'(b_fall), 8);

      // ---------------- asynchronous reset mid-line ----------------
      n = 0;
      while (d_x != 10'd700 && n < 2000) begin @(negedge Clk); n++; end
      check("mid_x700", 32'(d_x), 700);
      check("mid_hs_low", 32'(d_hs), 0);
      #3;
      Reset_n = 1'b0;
      #1;
      check("arst_x",    32'(d_x), 0);
      check("arst_y",    32'(d_y), 0);
      check("arst_hs",   32'(d_hs), 1);
      check("arst_vs",   32'(d_vs), 1);
      check("arst_bn",   32'(d_bn), 0);
      check("arst_pe",   32'(d_pe), 0);
      check("arst_fc_p0", 32'(a_fc), 0);
      check("arst_y_p0",  32'(a_y), 0);
      check("arst_hs_p3", 32'(b_hs), 1);
      check("arst_bn_p3", 32'(b_bn), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);
      check("arst_restart_x", 32'(d_x), 1);

      // ---------------- frame_count wrap ----------------
      force u_a.frame_cnt = 16'hFFFF;
      @(negedge Clk);
      release u_a.frame_cnt;
      @(negedge Clk);
      check("fc_preset", 32'(a_fc), 32'hFFFF);
      n = 0;
      while (a_y != 10'd7 && n < 300) begin @(negedge Clk); n++; end
      n = 0;
      while (a_y != 10'd0 && n < 64) begin @(negedge Clk); n++; end
      check("fc_wrap_p0", 32'(a_fc), 0);
      check("fc_one_p3",  32'(b_fc), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 50 MHz system clock. Drives the `DrawX`/`DrawY` pixel coordinates consumed by the colour mapper, and drives the `VGA_HS`/`VGA_VS`/`VGA_BLANK_N`/`VGA_CLK` pins. Syncs and blank are delayed by a programmable number of pixel periods so they stay aligned with the mapper's synchronous sprite-RAM read latency. Also provides frame-level pulses that game logic (player, NPC and police-car motion) uses as its update tick.

## Interface
- `H_VISIBLE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: horizontal sync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_VISIBLE`, 480: active lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vertical sync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `PIPE_DELAY`, 1: extra pixel periods of delay on HS/VS/BLANK_N; legal range 0..3
- `Clk` input 1: 50 MHz system clock; one clock domain only
- `Reset_n` input 1: asynchronous, active-low reset
- `DrawX` output 10: current horizontal count, 0..799
- `DrawY` output 10: current vertical count, 0..524
- `pixel_en` output 1: high on every second `Clk`; counters advance only on these edges
- `VGA_CLK` output 1: 25 MHz pixel clock, equal to `pixel_en`
- `VGA_HS` output 1: horizontal sync, active low
- `VGA_VS` output 1: vertical sync, active low
- `VGA_BLANK_N` output 1: high while in the active region
- `frame_start` output 1: one-`Clk` pulse at the start of each frame
- `vblank_start` output 1: one-`Clk` pulse at the start of vertical blank (game update tick)
- `frame_count` output 16: count of frames since reset; wraps

## Operation
- Totals: H_TOTAL = 800 and V_TOTAL = 525. Both are derived from the parameters in the package.
- `pix_phase` toggles every `Clk`. `pixel_en` = `pix_phase`.
- `hc` and `vc` are registers; `DrawX` = `hc` and `DrawY` = `vc`, with no further delay.
- On each `Clk` edge with `pixel_en` = 1:
  - `hc` increments.
  - At `hc` = 799, `hc` wraps to 0 and `vc` increments.
  - At `vc` = 524 with `hc` = 799, `vc` wraps to 0 and `frame_count` increments. `frame_count` wraps from 0xFFFF to 0.
- Decode of the next count:
  - HS is low when 656 ≤ `hc` ≤ 751.
  - VS is low when 490 ≤ `vc` ≤ 491.
  - BLANK_N is high when `hc` < 640 and `vc` < 480.
- The decode is registered on the same edge as the counters (stage 0). It then passes through a `PIPE_DELAY`-deep shift register that advances only on `pixel_en`. Outputs are taken from the last stage.
- `frame_start` is high during the `Clk` cycle in which the counters hold (0,0) and `pixel_en` = 1. It therefore fires once per frame.
- `vblank_start` is high during the `Clk` cycle in which the counters hold (0,480) and `pixel_en` = 1.
- Reset values:
  - `hc`, `vc`, `pix_phase` and `frame_count` reset to 0.
  - Every delay stage resets to HS = 1, VS = 1, BLANK_N = 0.
  - `frame_start` and `vblank_start` reset to 0. `frame_start` is suppressed until the first wrap, so the first frame after reset produces no pulse.
- Reset asserted mid-frame clears all state immediately, asynchronously. Counting restarts from (0,0) on the second `Clk` edge after `Reset_n` rises, i.e. the first `pixel_en` edge.
- No other inputs exist, so simultaneous-event conflicts are impossible. An H and V wrap on the same edge is the only coincident update; both occur together.

## Timing
- Line period: 1600 `Clk` cycles. Frame period: 840 000 `Clk` cycles.
- Each (`DrawX`, `DrawY`) value is stable for exactly two `Clk` cycles.
- Sync/blank latency relative to `DrawX`: 1 + `PIPE_DELAY` pixel periods. With the default of 1, an HS falling edge follows `DrawX` = 656 by 2 pixels (4 `Clk`).
- `frame_start` and `vblank_start` have zero latency relative to the counter value they decode.

## Structure
- Package `vga_timing_pkg` holds:
  - the H/V timing constants and the derived H_TOTAL, V_TOTAL, sync start/end values;
  - a packed struct `sync_bits_t` with fields `{hs, vs, blank_n}`.
- Sub-module `sync_delay_line` is a parameterised shift register of `sync_bits_t`. It has an enable input and an async active-low reset to the idle value. At `PIPE_DELAY` = 0 it is a pass-through.
- Counters, decode and pulse generation stay in the top module.

## Test plan
- **Reset:** hold `Reset_n` = 0 for 5 cycles → `DrawX` = `DrawY` = 0, HS = VS = 1, BLANK_N = 0, `frame_count` = 0. Release → `DrawX` = 1 after 2 `pixel_en` edges.
- **Line timing:** run one line → `DrawX` wraps 799 → 0 every 1600 `Clk`, `DrawY` increments at the wrap, and HS is low for exactly 192 `Clk` starting 4 `Clk` after `DrawX` first reads 656.
- **Frame timing:** run two frames → VS is low for 3200 `Clk` per frame, `frame_start` pulses exactly once per 840 000 `Clk`, `vblank_start` fires at (0,480), and `frame_count` = 2.
- **`PIPE_DELAY` = 0 and 3:** the HS/BLANK_N edges shift to 2 and 8 `Clk` respectively after the decoded count; pulse widths are unchanged.
- **Reset mid-frame:** assert `Reset_n` low at (300,200) → all outputs return to reset values within the same cycle, asynchronously, and the delay line holds idle values.
- **Wrap:** force `frame_count` to 0xFFFF, then complete the frame → `frame_count` reads 0x0000.
